phase_timer: RTL

Parametrised phase-duration timer for the traffic-light controller. Replaces the fixed-constant delay counter: per-phase durations come from a runtime duration bus, time advances in prescaled units, and the block adds hold, restart, a remaining-time output and select-error detection. It sits beside the light FSM. The FSM drives a one-hot phase select and advances on the Mealy `phase_end` pulse in the last cycle of each phase.

---
 rtl/phase_timer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//
// Phase-duration timer for the traffic-light controller. The light FSM drives a
// one-hot phase select; this block times the active phase using a per-phase
// duration taken from a runtime bus, counting in prescaled time units, and
// raises a Mealy end pulse in the last cycle of the phase so the FSM can
// advance on that same edge.
//
// Parameters
//   CNT_W      width of the unit counter, of each duration and of remaining
//   NUM_PHASES number of phases
//   PRESCALE   clock cycles per time unit (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   phase_sel  one-hot active phase from the FSM
//   dur_bus    duration of phase i (units) at dur_bus[i*CNT_W +: CNT_W]
//   hold       freezes timing while high
//   restart    synchronously restarts the current phase (overrides hold)
//   phase_end  one-hot, high in the last cycle of the active phase
//   any_end    OR of phase_end
//   remaining  units left in the active phase (0 when the select is invalid)
//   sel_err    phase_sel is not one-hot
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W      = 8,
    parameter int NUM_PHASES = 4,
    parameter int PRESCALE   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PHASES-1:0]       phase_sel,
    input  logic [NUM_PHASES*CNT_W-1:0] dur_bus,
    input  logic                        hold,
    input  logic                        restart,
    output logic [NUM_PHASES-1:0]       phase_end,
    output logic                        any_end,
    output logic [CNT_W-1:0]            remaining,
    output logic                        sel_err
);

    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]       ps_cnt;   // cycle within the current time unit
    logic [CNT_W-1:0]      el;       // whole units elapsed in this phase
    logic [NUM_PHASES-1:0] sel_q;    // select seen last cycle
    logic                  end_q;    // an end pulse was issued last cycle

    logic                  valid;
    logic [CNT_W-1:0]      dur_raw;
    logic [CNT_W-1:0]      dur;
    logic                  tick;
    logic                  last;
    logic                  sel_chg;
    logic                  clear;

    // One-hot test: non-zero with a single bit set.
    assign valid   = (phase_sel != '0) &&
                     ((phase_sel & (phase_sel - NUM_PHASES'(1))) == '0);
    assign sel_err = ~valid;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dur_raw = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase_sel[i]) begin
                dur_raw = dur_raw | dur_bus[i*CNT_W +: CNT_W];
            end
        end
    end

    // A zero duration behaves as one unit so every phase still ends.
    assign dur  = (dur_raw == '0) ? CNT_W'(1) : dur_raw;

    assign tick = valid & ~hold & (ps_cnt == PS_MAX);

    // >= rather than == so a duration lowered mid-phase ends on the next tick.
    // restart suppresses the pulse; rst_n keeps outputs quiet while in reset
    // (with PRESCALE=1 the cleared counters would otherwise look like a tick).
    assign last = tick & (el >= dur - CNT_W'(1)) & ~restart & rst_n;

    assign phase_end = phase_sel & {NUM_PHASES{last}};
    assign any_end   = |phase_end;

    // A select change that follows an end pulse is the normal FSM handshake;
    // only a change without a preceding end restarts timing.
    assign sel_chg = (phase_sel != sel_q) & ~end_q;
    assign clear   = restart | sel_chg | ~valid;

    assign remaining = !valid      ? '0 :
                       (el >= dur) ? '0 : dur - el;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
            el     <= '0;
            sel_q  <= '0;
            // Set so the first select after reset is not taken as a change.
            end_q  <= 1'b1;
        end else begin
            sel_q <= phase_sel;
            end_q <= any_end;
            if (clear || last) begin
                ps_cnt <= '0;
                el     <= '0;
            end else if (hold) begin
                ps_cnt <= ps_cnt;
                el     <= el;
            end else if (tick) begin
                ps_cnt <= '0;
                el     <= el + CNT_W'(1);
            end else begin
                ps_cnt <= ps_cnt + PS_W'(1);
            end
        end
    end

endmodule
